// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, parity encodings and the parity
// helper also used by the TX parity calculator.
package uart_pkg;

  localparam int unsigned MAX_DATA_WIDTH = 9;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  // Expected parity bit for a data word; narrower words are zero-extended by the caller.
  function automatic logic calc_parity(input logic [MAX_DATA_WIDTH-1:0] data,
                                       input logic                      par_typ);
    return (par_typ == PAR_EVEN) ? (^data) : ~(^data);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit timing for the UART receiver: sample counter, mid-bit 3-sample majority
// vote, and the decision (sample_done_c) / end-of-bit (bit_tick_c) strobes.
module uart_rx_sampler #(
  parameter int unsigned OVERSAMPLE = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic rxs,
  output logic sample_done_c,
  output logic bit_tick_c,
  output logic bit_val_c
);

  localparam int unsigned CW = $clog2(OVERSAMPLE);

  localparam logic [CW-1:0] MID_LO = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] MID    = CW'(OVERSAMPLE / 2);
  localparam logic [CW-1:0] MID_HI = CW'(OVERSAMPLE / 2 + 1);
  localparam logic [CW-1:0] LAST   = CW'(OVERSAMPLE - 1);

  logic [CW-1:0] smp_cnt;
  logic          s_lo;
  logic          s_mid;

  // Counter is held at 0 whenever the next cycle is not part of a frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      smp_cnt <= '0;
      s_lo    <= 1'b1;
      s_mid   <= 1'b1;
    end else begin
      if (!en) begin
        smp_cnt <= '0;
      end else if (bit_tick_c) begin
        smp_cnt <= '0;
      end else begin
        smp_cnt <= smp_cnt + CW'(1);
      end
      if (smp_cnt == MID_LO) s_lo  <= rxs;
      if (smp_cnt == MID)    s_mid <= rxs;
    end
  end

  // Third sample is the live line value at the decision point.
  assign sample_done_c = (smp_cnt == MID_HI);
  assign bit_tick_c    = (smp_cnt == LAST);
  assign bit_val_c     = (s_lo & s_mid) | (s_lo & rxs) | (s_mid & rxs);

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: synchroniser, start-bit validation, LSB-first
// deserialiser, optional parity check and stop-bit check. Optional parity via UART_RX_PARITY_EN.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned OVERSAMPLE = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic [DATA_WIDTH-1:0] p_data,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stop_err
);

  localparam int unsigned BCW = $clog2(DATA_WIDTH);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_WIDTH - 1);

  if ((OVERSAMPLE < 4) || ((OVERSAMPLE % 2) != 0)) begin : g_bad_oversample
    $error("uart_rx: OVERSAMPLE must be even and >= 4");
  end
  if ((DATA_WIDTH < 5) || (DATA_WIDTH > MAX_DATA_WIDTH)) begin : g_bad_width
    $error("uart_rx: DATA_WIDTH must be in 5..9");
  end

  logic                  sync1;
  logic                  rxs;
  rx_state_e             state_q;
  rx_state_e             state_d;
  logic [BCW-1:0]        bit_cnt;
  logic [DATA_WIDTH-1:0] shift_q;

  logic smp_en_c;
  logic sample_done_c;
  logic bit_tick_c;
  logic bit_val_c;
  logic cfg_ld_c;
  logic bit_wr_c;
  logic bit_adv_c;
  logic frame_end_c;
  logic frame_par_bad_c;

`ifdef UART_RX_PARITY_EN
  logic par_en_q;
  logic par_typ_q;
  logic par_bad_q;
  logic par_chk_c;
`endif

  // Two-flop synchroniser; reset to the idle line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= rx_in;
      rxs   <= sync1;
    end
  end

  // Counter runs on the IDLE cycle that first sees rxs low, making it sample 0.
  assign smp_en_c = (state_d != IDLE);

  uart_rx_sampler #(
    .OVERSAMPLE (OVERSAMPLE)
  ) u_sampler (
    .clk           (clk),
    .rst           (rst),
    .en            (smp_en_c),
    .rxs           (rxs),
    .sample_done_c (sample_done_c),
    .bit_tick_c    (bit_tick_c),
    .bit_val_c     (bit_val_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cfg_ld_c    = 1'b0;
    bit_wr_c    = 1'b0;
    bit_adv_c   = 1'b0;
    frame_end_c = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_chk_c   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (!rxs) state_d = START;
      end
      START: begin
        if (sample_done_c && bit_val_c) begin
          state_d = IDLE;
        end else if (bit_tick_c) begin
          state_d  = DATA;
          cfg_ld_c = 1'b1;
        end
      end
      DATA: begin
        bit_wr_c = sample_done_c;
        if (bit_tick_c) begin
          bit_adv_c = 1'b1;
          if (bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
            state_d = par_en_q ? PARITY : STOP;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        par_chk_c = sample_done_c;
        if (bit_tick_c) state_d = STOP;
      end
`endif
      // Leave at the decision point so a short stop bit still allows back-to-back frames.
      STOP: begin
        if (sample_done_c) begin
          state_d     = IDLE;
          frame_end_c = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt    <= '0;
      shift_q    <= '0;
      p_data     <= '0;
      data_valid <= 1'b0;
      stop_err   <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      stop_err   <= 1'b0;
      if (cfg_ld_c) begin
        bit_cnt <= '0;
      end else if (bit_adv_c) begin
        bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + BCW'(1);
      end
      if (bit_wr_c) shift_q[bit_cnt] <= bit_val_c;
      if (frame_end_c) begin
        stop_err <= ~bit_val_c;
        if (bit_val_c && !frame_par_bad_c) begin
          data_valid <= 1'b1;
          p_data     <= shift_q;
        end
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  assign frame_par_bad_c = par_bad_q;

  // Frame format is latched on leaving START and held until the next frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      par_en_q  <= 1'b0;
      par_typ_q <= PAR_EVEN;
      par_bad_q <= 1'b0;
      par_err   <= 1'b0;
    end else begin
      par_err <= 1'b0;
      if (cfg_ld_c) begin
        par_en_q  <= par_en;
        par_typ_q <= par_typ;
        par_bad_q <= 1'b0;
      end
      if (par_chk_c) begin
        par_bad_q <= (bit_val_c != calc_parity(MAX_DATA_WIDTH'(shift_q), par_typ_q));
      end
      if (frame_end_c) par_err <= par_bad_q;
    end
  end
`else
  logic unused_par_c;

  assign frame_par_bad_c = 1'b0;
  assign par_err         = 1'b0;
  assign unused_par_c    = ^{par_en, par_typ};
`endif

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
Oversampling UART receiver; the receive-side counterpart of the TX path's serializer.
- Synchronises the asynchronous serial line and detects and validates the start bit.
- Majority-samples each bit at mid-period, deserialises LSB-first into a parallel word, and checks parity and stop bit.
- Delivers p_data with a one-cycle data_valid pulse to the downstream consumer (register file / RX FIFO).

Parameters:
- DATA_WIDTH, 8, number of data bits per frame (5..9).
- OVERSAMPLE, 8, clk cycles per bit period. Must be even and >= 4; otherwise elaboration fails.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- rx_in  in  1  asynchronous serial line; idle high.
- par_en  in  1  1 = frame carries a parity bit after the data bits.
- par_typ  in  1  0 = even parity, 1 = odd parity.
- p_data  out  DATA_WIDTH  received word; holds its value until the next good frame.
- data_valid  out  1  one-cycle pulse: p_data updated with an error-free frame.
- par_err  out  1  one-cycle pulse: parity mismatch in the frame just ended.
- stop_err  out  1  one-cycle pulse: stop bit sampled low (framing error).

Behaviour:
- Reset: synchronous active-high, applied on rising clk with rst=1.
  - p_data=0; data_valid, par_err, stop_err = 0.
  - FSM=IDLE; counters 0; synchroniser flops = 1.
  - Mid-frame reset aborts the frame with no output pulse.
- Synchroniser: 2-flop on rx_in. All decisions use the synchronised signal rxs, which lags rx_in by 2 clk.
- Bit timing:
  - smp_cnt counts 0..OVERSAMPLE-1 within each bit and wraps to 0.
  - rxs is captured at smp_cnt = OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1.
  - The bit value is the majority of the 3 samples, decided at smp_cnt = OVERSAMPLE/2+1.
- FSM states IDLE, START, DATA, PARITY, STOP:
  - IDLE: when rxs=0, go to START with smp_cnt=0 (that cycle is sample 0 of the start bit).
  - START: at the decision point, majority=1 means a glitch; return to IDLE with no outputs. Majority=0 means continue; go to DATA when smp_cnt wraps.
  - DATA: bit_cnt 0..DATA_WIDTH-1; the decided bit is written into shift position bit_cnt (LSB first). After the last bit wraps, go to PARITY if par_en, else STOP.
  - PARITY: the decided bit is compared with the computed parity. Even parity = XOR of data bits; odd parity = its inverse. Go to STOP.
  - STOP: at the decision point, go to IDLE immediately, without waiting for smp_cnt to wrap. This allows back-to-back frames with a stop bit of at least 0.6 bit period.
- Frame end outputs, in the cycle after the stop-bit decision:
  - stop ok and no parity error: p_data <= shift register; data_valid=1.
  - parity mismatch: par_err=1; p_data is not updated.
  - stop bit = 0: stop_err=1; p_data is not updated. Both error pulses may assert together.
- par_en and par_typ are sampled when leaving START and held for the rest of the frame; changes mid-frame are ignored.
- Latency, OVERSAMPLE=8, 8N1: data_valid rises 2 + 9*8 + 5 + 1 = 80 clk after the rx_in falling edge of the start bit.
- rx_in held low continuously: stop_err pulses once per frame; no data_valid.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined: PARITY state, the par_en/par_typ ports and par_err exist as described.
- Undefined:
  - The PARITY state is not compiled; DATA always goes to STOP.
  - par_en and par_typ remain as ports but are ignored.
  - par_err is tied to 0.
  - Frame format is fixed at 8N1-style (DATA_WIDTH data bits, no parity).

Decomposition:
- Package uart_pkg:
  - rx FSM state enum (IDLE, START, DATA, PARITY, STOP);
  - PAR_EVEN=1'b0, PAR_ODD=1'b1;
  - function computing parity from a data word and par_typ. This function is shared with the TX parity calculator.
- Sub-module uart_rx_sampler: owns smp_cnt, the 3-sample majority vote, and the strobes sample_done/bit_tick. It is reused by the top FSM.

Test Plan:
- 8N1, OVERSAMPLE=8, send 0xA5 -> data_valid pulses exactly once, 80 clk after the start edge; p_data=0xA5; par_err=stop_err=0.
- par_en=1, par_typ=0, send 0x3C with parity bit 0 -> data_valid, p_data=0x3C. Repeat with parity bit 1 -> par_err pulse, no data_valid, p_data stays 0x3C.
- Send 0x55 with the stop bit driven low -> stop_err pulse, no data_valid, p_data unchanged.
- rx_in low glitch of 2 clk while idle -> returns to IDLE; no output pulses; a following frame of 0x81 is received correctly.
- Back-to-back frames 0x00, 0xFF, 0x5A with no idle gap -> three data_valid pulses in order with the correct values.
- rst asserted in the middle of DATA, then released, then a frame of 0xC3 is sent -> no pulse from the aborted frame; 0xC3 is received correctly.
